// File: rtl/keygen_arbiter.sv
// Round-robin arbiter that shares a single key-generation engine among N_REQ requesters.
// Optional watchdog abort is compiled in with the KEYGEN_WDT_EN macro.
module keygen_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WDT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] ack_o,
    output logic [N_REQ-1:0] err_o,
    output logic [511:0]     pub_key_o,
    output logic [255:0]     priv_key_o,
    output logic             busy_o,
    output logic             eng_start_o,
    input  logic             eng_complete_i,
    input  logic [511:0]     eng_public_key_i,
    input  logic [255:0]     eng_private_key_i
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        DELIVER
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0]    ptr;
    logic [IW-1:0]    ptr_next;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    owner_next;
    logic [IW-1:0]    cand;
    logic [IW-1:0]    grant_idx;
    logic             grant_found;
    logic [N_REQ-1:0] owner_onehot;

    logic [511:0]     pub_reg;
    logic [255:0]     priv_reg;
    logic [N_REQ-1:0] ack_reg;
    logic [511:0]     pub_out;
    logic [255:0]     priv_out;

    assign owner_onehot = N_REQ'(1) << owner;

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr) + k) % N_REQ);
            if (!grant_found && req_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

`ifdef KEYGEN_WDT_EN
    logic [15:0]      wdt_cnt;
    logic             wdt_expire;
    logic [N_REQ-1:0] err_reg;

    assign wdt_expire = (state == WAIT) && (wdt_cnt == 16'(WDT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdt_cnt <= '0;
        end else if (state == START) begin
            wdt_cnt <= '0;
        end else if (state == WAIT) begin
            wdt_cnt <= wdt_cnt + 16'd1;
        end
    end

    // A completion arriving in the expiry cycle takes priority over the abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_reg <= '0;
        end else if (wdt_expire && !eng_complete_i) begin
            err_reg <= owner_onehot;
        end else begin
            err_reg <= '0;
        end
    end

    assign err_o = err_reg;
`else
    assign err_o = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= IW'(N_REQ - 1);
            owner <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            owner <= owner_next;
        end
    end

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        owner_next = owner;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    owner_next = grant_idx;
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (eng_complete_i) begin
                    state_next = DELIVER;
                end
`ifdef KEYGEN_WDT_EN
                else if (wdt_expire) begin
                    ptr_next   = owner;
                    state_next = IDLE;
                end
`endif
            end
            DELIVER: begin
                ptr_next   = owner;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Engine keys live internally only between completion and the delivery decision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pub_reg  <= '0;
            priv_reg <= '0;
        end else if (state == WAIT && eng_complete_i) begin
            pub_reg  <= eng_public_key_i;
            priv_reg <= eng_private_key_i;
        end else if (state != WAIT) begin
            pub_reg  <= '0;
            priv_reg <= '0;
        end
    end

    // Outputs are registered so keys appear only in the single ack cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_reg  <= '0;
            pub_out  <= '0;
            priv_out <= '0;
        end else if (state == DELIVER && req_i[owner]) begin
            ack_reg  <= owner_onehot;
            pub_out  <= pub_reg;
            priv_out <= priv_reg;
        end else begin
            ack_reg  <= '0;
            pub_out  <= '0;
            priv_out <= '0;
        end
    end

    assign ack_o       = ack_reg;
    assign pub_key_o   = pub_out;
    assign priv_key_o  = priv_out;
    assign busy_o      = (state != IDLE);
    assign eng_start_o = (state == START);

endmodule
